// File: rtl/alu_exec_pkg.sv
// Shared op codes, widths and FSM state encoding for the execute-stage ALU.
// Optional signed-overflow detection is enabled with ALU_OVERFLOW_EN.
package alu_exec_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;

  localparam logic [3:0] ALU_OP_SUB = 4'b0001;
  localparam logic [3:0] ALU_OP_OR  = 4'b0010;
  localparam logic [3:0] ALU_OP_ADD = 4'b0011;
  localparam logic [3:0] ALU_OP_LUI = 4'b0100;
  localparam logic [3:0] ALU_OP_SLL = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ADD/SUB/OR/LUI datapath with illegal-code and overflow flags.
// Overflow detection exists only when ALU_OVERFLOW_EN is defined.
module alu_comb_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_o,
  output logic                  overflow_o
);
  import alu_exec_pkg::*;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (alu_operation_i)
      ALU_OP_SUB: result_o = diff;
      ALU_OP_OR:  result_o = a_i | b_i;
      ALU_OP_ADD: result_o = sum;
      ALU_OP_LUI: result_o = b_i << 16;
      // Zero-length shift; multi-bit shifts are sequenced by the top level
      ALU_OP_SLL: result_o = b_i;
      default:    illegal_o = 1'b1;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  localparam int unsigned MSB = DATA_WIDTH - 1;

  always_comb begin
    overflow_o = 1'b0;
    case (alu_operation_i)
      ALU_OP_ADD: overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      ALU_OP_SUB: overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      default:    overflow_o = 1'b0;
    endcase
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready in and out, registered result, iterative SLL.
// Signed-overflow flag is live only when ALU_OVERFLOW_EN is defined.
module alu_exec_unit #(
  parameter int unsigned DATA_WIDTH  = alu_exec_pkg::DATA_WIDTH,
  parameter int unsigned SHAMT_WIDTH = alu_exec_pkg::SHAMT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   illegal_o,
  output logic                   overflow_o
);
  import alu_exec_pkg::*;

  alu_state_e state_q;
  alu_state_e state_d;

  logic [DATA_WIDTH-1:0]  result_q;
  logic                   zero_q;
  logic                   illegal_q;
  logic                   overflow_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;

  logic [DATA_WIDTH-1:0]  core_result;
  logic                   core_illegal;
  logic                   core_overflow;
  logic [DATA_WIDTH-1:0]  single_res;
  logic [DATA_WIDTH-1:0]  acc_next;
  logic                   accept;
  logic                   is_sll;
  logic                   sll_multi;
  logic                   shift_last;

  alu_comb_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .result_o        (core_result),
    .illegal_o       (core_illegal),
    .overflow_o      (core_overflow)
  );

  assign accept     = valid_i && (state_q == ST_IDLE);
  assign is_sll     = (alu_operation_i == ALU_OP_SLL);
  assign sll_multi  = is_sll && (shamt_i > SHAMT_WIDTH'(1));
  assign single_res = (is_sll && (shamt_i == SHAMT_WIDTH'(1))) ? (b_i << 1) : core_result;
  assign acc_next   = acc_q << 1;
  assign shift_last = (cnt_q == SHAMT_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = sll_multi ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (shift_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first shift happens on the accept edge, so an n-bit SLL delivers
  // its result n edges after accept (counter is loaded with n-1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (sll_multi) begin
              acc_q      <= b_i << 1;
              cnt_q      <= shamt_i - 1'b1;
              illegal_q  <= 1'b0;
              overflow_q <= 1'b0;
            end else begin
              result_q   <= single_res;
              zero_q     <= (single_res == '0);
              illegal_q  <= core_illegal;
              overflow_q <= core_overflow;
            end
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - 1'b1;
          if (shift_last) begin
            result_q <= acc_next;
            zero_q   <= (acc_next == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign illegal_o  = illegal_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit; expected overflow follows ALU_OVERFLOW_EN.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [4:0]  shamt_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;
  logic        overflow_o;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .shamt_i         (shamt_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .illegal_o       (illegal_o),
    .overflow_o      (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t        m;
    logic [32:0] wide;
    logic        ovf_calc;
    m.tag = tag;
    m.ill = 1'b0;
    m.ovf = 1'b0;
    m.lat = 1;
    ovf_calc = 1'b0;
    case (op)
      4'b0001: begin
        m.res = a - b;
        wide = {a[31], a} - {b[31], b};
        ovf_calc = wide[32] ^ wide[31];
      end
      4'b0010: m.res = a | b;
      4'b0011: begin
        m.res = a + b;
        wide = {a[31], a} + {b[31], b};
        ovf_calc = wide[32] ^ wide[31];
      end
      4'b0100: m.res = {b[15:0], 16'h0000};
      4'b0101: begin
        m.res = b << sh;
        m.lat = (sh == 5'd0) ? 1 : int'(sh);
      end
      default: begin
        m.res = 32'h0;
        m.ill = 1'b1;
      end
    endcase
`ifdef ALU_OVERFLOW_EN
    m.ovf = ovf_calc;
`endif
    m.zero = (m.res == 32'h0);
    return m;
  endfunction

  // Issue one op, wait for its result, compare against the scoreboard head,
  // optionally hold ready_i low for `hold` cycles while poking valid_i.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold);
    exp_t        e;
    int          n;
    logic [31:0] r_hold;
    logic        z_hold;
    logic        i_hold;
    sb.push_back(model(tag, op, a, b, sh));
    n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".ready_before"}, {31'h0, ready_o}, 32'h1);
    ready_i = (hold == 0);
    valid_i = 1'b1;
    alu_operation_i = op;
    a_i = a;
    b_i = b;
    shamt_i = sh;
    @(posedge clk); #1;
    valid_i = 1'b0;
    alu_operation_i = 4'b1111;
    a_i = ~a;
    b_i = 32'h5A5A_5A5A;
    shamt_i = ~sh;
    n = 1;
    while (!valid_o && n < 40) begin
      check({tag, ".ready_busy"}, {31'h0, ready_o}, 32'h0);
      @(posedge clk); #1; n++;
    end
    e = sb.pop_front();
    check({e.tag, ".latency"}, n, e.lat);
    check({e.tag, ".result"}, result_o, e.res);
    check({e.tag, ".zero"}, {31'h0, zero_o}, {31'h0, e.zero});
    check({e.tag, ".illegal"}, {31'h0, illegal_o}, {31'h0, e.ill});
    check({e.tag, ".overflow"}, {31'h0, overflow_o}, {31'h0, e.ovf});
    if (hold > 0) begin
      r_hold = result_o;
      z_hold = zero_o;
      i_hold = illegal_o;
      for (int k = 0; k < hold; k++) begin
        valid_i = 1'b1;
        alu_operation_i = 4'b0011;
        a_i = 32'h1111_0000 + k;
        @(posedge clk); #1;
        check({e.tag, ".hold_valid"}, {31'h0, valid_o}, 32'h1);
        check({e.tag, ".hold_ready"}, {31'h0, ready_o}, 32'h0);
        check({e.tag, ".hold_result"}, result_o, e.res);
        check({e.tag, ".hold_flags"}, {30'h0, zero_o, illegal_o}, {30'h0, z_hold, i_hold});
      end
      check({e.tag, ".hold_final"}, result_o, r_hold);
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(posedge clk); #1;
    check({e.tag, ".released_valid"}, {31'h0, valid_o}, 32'h0);
    check({e.tag, ".released_ready"}, {31'h0, ready_o}, 32'h1);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    alu_operation_i = 4'b0000;
    a_i = '0;
    b_i = '0;
    shamt_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst.ready", {31'h0, ready_o}, 32'h1);
    check("rst.valid", {31'h0, valid_o}, 32'h0);
    check("rst.result", result_o, 32'h0);
    check("rst.zero", {31'h0, zero_o}, 32'h1);
    check("rst.illegal", {31'h0, illegal_o}, 32'h0);
    check("rst.overflow", {31'h0, overflow_o}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_5_7",    4'b0011, 32'd5,          32'd7,          5'd0,  0);
    run_op("sub_eq",     4'b0001, 32'd7,          32'd7,          5'd0,  0);
    run_op("sub_wrap",   4'b0001, 32'd0,          32'd1,          5'd0,  0);
    run_op("or",         4'b0010, 32'hF0F0_0000,  32'h0000_0F0F,  5'd0,  0);
    run_op("sll_4",      4'b0101, 32'hDEAD_BEEF,  32'h0000_0001,  5'd4,  0);
    run_op("sll_31",     4'b0101, 32'h0,          32'h0000_0001,  5'd31, 0);
    run_op("sll_0",      4'b0101, 32'h0,          32'h1234_5678,  5'd0,  0);
    run_op("sll_1",      4'b0101, 32'h0,          32'h8000_0003,  5'd1,  0);
    run_op("sll_2_zero", 4'b0101, 32'h0,          32'hC000_0000,  5'd2,  0);
    run_op("lui",        4'b0100, 32'h0,          32'h0000_ABCD,  5'd0,  0);
    run_op("illegal",    4'b1001, 32'h1,          32'h2,          5'd3,  0);
    run_op("add_clears", 4'b0011, 32'hFFFF_FFFF,  32'h0000_0002,  5'd0,  0);
    run_op("ovf_add",    4'b0011, 32'h7FFF_FFFF,  32'h0000_0001,  5'd0,  0);
    run_op("ovf_sub",    4'b0001, 32'h8000_0000,  32'h0000_0001,  5'd0,  0);
    run_op("backpress",  4'b0011, 32'd100,        32'd23,         5'd0,  5);
    run_op("sll_bp",     4'b0101, 32'h0,          32'h0000_0003,  5'd3,  2);

    // Reset two edges into a 10-bit shift: the op must vanish without valid_o.
    valid_i = 1'b1;
    alu_operation_i = 4'b0101;
    b_i = 32'h0000_0001;
    shamt_i = 5'd10;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.busy", {31'h0, ready_o}, 32'h0);
    reset = 1'b1;
    #1;
    check("rst_mid.ready", {31'h0, ready_o}, 32'h1);
    check("rst_mid.valid", {31'h0, valid_o}, 32'h0);
    check("rst_mid.result", result_o, 32'h0);
    check("rst_mid.zero", {31'h0, zero_o}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    check("rst_mid.no_valid", seen, 0);

    run_op("after_rst",  4'b0011, 32'd1,          32'd2,          5'd0,  0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
